muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer sitting beside the ALU in the execute stage.
- Accepts one M-extension op from E, runs a 32-step shift-add multiply or restoring divide, and raises a stall to F/D/E while busy.
- Returns the result with destination register for merging into the E/M path.
- Hazard unit ORs busy_o into its stall and flush logic.

Parameters:
- D_WIDTH, 32, operand/result width; iteration count equals D_WIDTH.
- CNT_W, 6, iteration counter width (must hold D_WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  valid M-op present in E (opcode OP, funct7=0000001)
- funct3  input  3  M-op select
- op_a  input  D_WIDTH  rs1 value (post-forwarding)
- op_b  input  D_WIDTH  rs2 value (post-forwarding)
- rd_i  input  5  destination register
- flush_i  input  1  abort current op (branch/jump flush of E)
- busy_o  output  1  stall request to F/D/E
- done_o  output  1  one-cycle result-valid pulse
- result_o  output  D_WIDTH  result, held until next completion
- rd_o  output  5  destination of result_o

Behaviour:
- Reset: state IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0, counter=0.
- States:
  - IDLE: start_i && !flush_i → latch funct3/rd_i/operands. Div-by-zero or signed overflow → DONE; multiply → MUL; otherwise → DIV.
  - MUL / DIV: one iteration per cycle. After the D_WIDTH-th iteration → FIX.
  - FIX: sign correction, write result_o/rd_o → DONE.
  - DONE: done_o=1 → IDLE. start_i ignored in DONE (same instruction still sits in E).
- busy_o: (IDLE && start_i && !flush_i) || MUL || DIV || FIX. busy_o is combinational so the stall applies in the start cycle. busy_o=0 in DONE so the pipeline advances with the result.
- Latency: start accepted in cycle t → done_o in cycle t+D_WIDTH+2 (t+34). Special cases → done_o at t+1.
- Multiply:
  - Works on 2·D_WIDTH-bit magnitudes.
  - Operand signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Product negated in FIX if signs differ.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide:
  - Restoring algorithm on magnitudes.
  - Quotient negated if signs differ (DIV).
  - Remainder takes the dividend sign (REM).
  - DIVU/REMU take no sign correction.
- Special cases, per the RISC-V spec:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- flush_i in any state → IDLE next cycle, no done_o. result_o/rd_o keep their previous values. flush_i in the start cycle prevents acceptance.
- rst mid-operation: full reset next edge, no done_o.
- Operands are latched at start; input changes during MUL/DIV/FIX have no effect.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 constants: F3_MUL=000, F3_MULH=001, F3_MULHSU=010, F3_MULHU=011, F3_DIV=100, F3_DIVU=101, F3_REM=110, F3_REMU=111.
  - State enum: IDLE, MUL, DIV, FIX, DONE.
  - Helper: is_div(funct3) = funct3[2].
- One sub-module is natural: muldiv_core. It holds the accumulator/remainder registers plus per-iteration shift-add and shift-subtract logic, with a step enable and mode input. muldiv_seq keeps the FSM, counter, sign handling, special cases and handshake.

Test Plan:
- MUL 7 × −3 (op_b=0xFFFFFFFD), start at t → busy_o high t..t+33; done_o at t+34 only; result_o=0xFFFFFFEB; rd_o=rd_i.
- MULH and MULHU with op_a=op_b=0x80000000 → MULH 0x40000000; MULHU 0x40000000. MULHSU with op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA (−6); REM −20/3 → 0xFFFFFFFE (−2); DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
- Divisor zero: DIVU 5/0 → 0xFFFFFFFF at t+1; REM 5/0 → 5. Overflow: DIV 0x80000000/−1 → 0x80000000 at t+1; REM → 0.
- flush_i at t+10 of a DIV → IDLE at t+11, busy_o low, no done_o, result_o unchanged. rst at t+5 → all outputs 0 next cycle.
- Back-to-back ops:
  - start_i held through DONE → exactly one done_o.
  - New start_i the cycle after DONE → accepted; second result correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 encodings of the M-extension ops, the sequencer state type and a
// small helper that tells divide-class ops apart from multiply-class ops.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

  // funct3 encodings of the eight M-extension operations
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  // Bit 2 of funct3 separates the divide/remainder group from the multiplies
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
// Datapath of the sequencer: a 2*D_WIDTH accumulator plus the operand that
// is added (multiply) or subtracted (divide) in each iteration. Both
// algorithms share the same register and the same load pattern
// {zeros, op_a}, with op_b held as the per-step operand.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : capture operand magnitudes (start of an operation)
//   i_step    : perform one iteration this cycle
//   i_div     : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_a, i_b  : operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   o_acc     : accumulator; product, or {remainder, quotient}
// -----------------------------------------------------------------------------
module muldiv_core #(
  parameter int D_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic                   i_div,
  input  logic [D_WIDTH-1:0]     i_a,
  input  logic [D_WIDTH-1:0]     i_b,
  output logic [2*D_WIDTH-1:0]   o_acc
);

  logic [2*D_WIDTH-1:0] r_acc;
  logic [D_WIDTH-1:0]   r_m;

  logic [D_WIDTH:0]     w_sum;
  logic [2*D_WIDTH-1:0] w_mulNext;
  logic [D_WIDTH:0]     w_shifted;
  logic                 w_ge;
  logic [D_WIDTH-1:0]   w_diff;
  logic [2*D_WIDTH-1:0] w_divNext;

  // Next-value logic for one iteration of either algorithm.
  // Multiply: the multiplier sits in the low half and drains out to the
  // right while the partial product grows in the high half.
  // Divide: the dividend shifts left out of the low half into the partial
  // remainder; the quotient bit enters at bit 0. The subtraction only needs
  // D_WIDTH bits because a successful subtract always leaves a remainder
  // smaller than the divisor.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*D_WIDTH-1:D_WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    w_mulNext = {w_sum, r_acc[D_WIDTH-1:1]};
    w_shifted = {r_acc[2*D_WIDTH-1:D_WIDTH], r_acc[D_WIDTH-1]};
    w_ge      = (w_shifted >= {1'b0, r_m});
    w_diff    = w_shifted[D_WIDTH-1:0] - r_m;
    w_divNext = w_ge ? {w_diff, r_acc[D_WIDTH-2:0], 1'b1}
                     : {w_shifted[D_WIDTH-1:0], r_acc[D_WIDTH-2:0], 1'b0};
  end

  // Accumulator and step operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_m   <= '0;
    end else if (i_load) begin
      r_acc <= {{D_WIDTH{1'b0}}, i_a};
      r_m   <= i_b;
    end else if (i_step) begin
      r_acc <= i_div ? w_divNext : w_mulNext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative RV32M multiply/divide sequencer beside the execute-stage ALU.
// Accepts one M-op, runs D_WIDTH shift-add or restoring-divide steps on
// operand magnitudes, applies the sign correction and returns the result
// with its destination register. Stalls the front of the pipe while busy.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : valid M-op present in E
//   funct3          : M-op select
//   op_a, op_b      : rs1 / rs2 values
//   rd_i            : destination register
//   flush_i         : abort current op
//   busy_o          : stall request (combinational)
//   done_o          : one-cycle result-valid pulse
//   result_o, rd_o  : result and its destination, held until next completion
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] op_a,
  input  logic [D_WIDTH-1:0] op_b,
  input  logic [4:0]         rd_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [D_WIDTH-1:0] result_o,
  output logic [4:0]         rd_o
);

  localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_f3;
  logic [4:0]         r_rd;
  logic               r_negRes;
  logic               r_negRem;

  logic                 w_accept;
  logic                 w_aSigned;
  logic                 w_bSigned;
  logic                 w_aNeg;
  logic                 w_bNeg;
  logic [D_WIDTH-1:0]   w_aMag;
  logic [D_WIDTH-1:0]   w_bMag;
  logic                 w_special;
  logic [D_WIDTH-1:0]   w_specialRes;
  logic [2*D_WIDTH-1:0] w_acc;
  logic [2*D_WIDTH-1:0] w_prod;
  logic [D_WIDTH-1:0]   w_quot;
  logic [D_WIDTH-1:0]   w_rem;
  logic [D_WIDTH-1:0]   w_fixRes;

  assign w_accept = (r_state == IDLE) && start_i && !flush_i;

  // Operand signedness and magnitudes taken straight from the inputs in the
  // start cycle. rs1 is signed for everything except MULHU/DIVU/REMU; rs2 is
  // signed only for MUL/MULH/DIV/REM. MUL's low word is the same either way.
  // A most-negative operand negates to itself, which is the right unsigned
  // magnitude.
  always_comb begin
    w_aSigned = !(funct3 == F3_MULHU || funct3 == F3_DIVU || funct3 == F3_REMU);
    w_bSigned = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                (funct3 == F3_DIV) || (funct3 == F3_REM);
    w_aNeg    = w_aSigned && op_a[D_WIDTH-1];
    w_bNeg    = w_bSigned && op_b[D_WIDTH-1];
    w_aMag    = w_aNeg ? -op_a : op_a;
    w_bMag    = w_bNeg ? -op_b : op_b;
  end

  // Divide-by-zero and signed overflow bypass the iterations entirely.
  // Only DIV/REM (funct3[0] clear) can overflow; the overflow quotient is
  // the dividend itself.
  always_comb begin
    w_special    = 1'b0;
    w_specialRes = '0;
    if (is_div(funct3)) begin
      if (op_b == '0) begin
        w_special    = 1'b1;
        w_specialRes = funct3[1] ? op_a : '1;
      end else if (!funct3[0] && op_a == MIN_NEG && op_b == '1) begin
        w_special    = 1'b1;
        w_specialRes = funct3[1] ? '0 : op_a;
      end
    end
  end

  muldiv_core #(.D_WIDTH(D_WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_step ((r_state == MUL) || (r_state == DIV)),
    .i_div  (r_state == DIV),
    .i_a    (w_aMag),
    .i_b    (w_bMag),
    .o_acc  (w_acc)
  );

  // Sign correction applied in FIX. The quotient and product flip when the
  // operand signs differ; the remainder follows the dividend sign.
  always_comb begin
    w_prod = r_negRes ? -w_acc : w_acc;
    w_quot = r_negRes ? -w_acc[D_WIDTH-1:0] : w_acc[D_WIDTH-1:0];
    w_rem  = r_negRem ? -w_acc[2*D_WIDTH-1:D_WIDTH] : w_acc[2*D_WIDTH-1:D_WIDTH];
    if (is_div(r_f3))
      w_fixRes = r_f3[1] ? w_rem : w_quot;
    else if (r_f3 == F3_MUL)
      w_fixRes = w_prod[D_WIDTH-1:0];
    else
      w_fixRes = w_prod[2*D_WIDTH-1:D_WIDTH];
  end

  // Stall is combinational so it already holds the pipe in the start cycle;
  // it drops in DONE so the instruction advances together with its result.
  assign busy_o = w_accept || (r_state == MUL) || (r_state == DIV) || (r_state == FIX);

  // Sequencer: flush always wins and returns to IDLE without touching the
  // held result. DONE ignores start_i because the same instruction is still
  // sitting in E during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_f3     <= funct3;
              r_rd     <= rd_i;
              r_negRes <= w_aNeg ^ w_bNeg;
              r_negRem <= w_aNeg;
              r_cnt    <= '0;
              if (w_special) begin
                result_o <= w_specialRes;
                rd_o     <= rd_i;
                done_o   <= 1'b1;
                r_state  <= DONE;
              end else if (is_div(funct3)) begin
                r_state <= DIV;
              end else begin
                r_state <= MUL;
              end
            end
          end
          MUL, DIV: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(D_WIDTH - 1))
              r_state <= FIX;
          end
          FIX: begin
            result_o <= w_fixRes;
            rd_o     <= r_rd;
            done_o   <= 1'b1;
            r_state  <= DONE;
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Self-checking bench for muldiv_seq. Expected outputs come from an
// arithmetic model of the M-extension ops plus a cycle-level timeline
// (busy window, done cycle, held result) that the stimulus tasks maintain.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  muldiv_seq #(.D_WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3   (funct3),
    .op_a     (op_a),
    .op_b     (op_b),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  // Free-running clock and a cycle index that advances on every rising edge
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Expected timeline for the cycle currently being observed
  bit          checkEn     = 1'b0;
  int          expBusyFrom = -1;
  int          expBusyTo   = -1;
  int          expDoneCyc  = -1;
  logic [31:0] pendRes     = '0;
  logic [4:0]  pendRd      = '0;
  logic [31:0] expResult   = '0;
  logic [4:0]  expRd       = '0;

  // Reference arithmetic for the eight M-extension ops
  function automatic logic [31:0] refOp(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = int'(a);
    ib = int'(b);
    r  = '0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF :
                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a :
                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Ops that finish one cycle after acceptance
  function automatic bit isSpecial(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the expected timeline, away from the edge
  always @(negedge clk) begin
    if (checkEn) begin
      if (cyc == expDoneCyc) begin
        expResult = pendRes;
        expRd     = pendRd;
      end
      checkOutput("busy_o", {31'b0, busy_o}, {31'b0, (cyc >= expBusyFrom && cyc < expBusyTo)});
      checkOutput("done_o", {31'b0, done_o}, {31'b0, (cyc == expDoneCyc)});
      checkOutput("result_o", result_o, expResult);
      checkOutput("rd_o", {27'b0, rd_o}, {27'b0, expRd});
    end
  end

  // Issue one op in the current cycle and follow it to completion.
  // hold keeps start_i high through DONE; flushAt/rstAt (cycles after start,
  // 0 = start cycle for flush, -1 = never) abort the op.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] res, input bit hold,
                               input int flushAt, input int rstAt);
    int t;
    int lat;
    t   = cyc;
    lat = isSpecial(f3, a, b) ? 1 : 34;
    start_i = 1'b1;
    funct3  = f3;
    op_a    = a;
    op_b    = b;
    rd_i    = rd;
    if (flushAt == 0) begin
      flush_i     = 1'b1;
      expBusyFrom = t;
      expBusyTo   = t;
      expDoneCyc  = -1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      start_i = 1'b0;
      return;
    end
    expBusyFrom = t;
    expBusyTo   = t + lat;
    expDoneCyc  = t + lat;
    pendRes     = res;
    pendRd      = rd;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start_i = hold;
      funct3  = 3'($urandom);
      op_a    = $urandom;
      op_b    = $urandom;
      rd_i    = 5'($urandom);
      if (k == flushAt) begin
        flush_i    = 1'b1;
        expBusyTo  = t + k + 1;
        expDoneCyc = -1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        return;
      end
      if (k == rstAt) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        start_i    = 1'b0;
        expBusyTo  = cyc;
        expDoneCyc = -1;
        expResult  = '0;
        expRd      = '0;
        return;
      end
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    funct3  = '0;
    op_a    = '0;
    op_b    = '0;
    rd_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;
    $display("[TB] reset released at cycle %0d", cyc);

    // Hand-computed values pinning the reference model
    checkOutput("model MUL 7*-3",        refOp(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    checkOutput("model MULH min*min",    refOp(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    checkOutput("model MULHSU -1*max",   refOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    checkOutput("model REM -20/3",       refOp(3'd6, 32'hFFFFFFEC, 32'd3), 32'hFFFFFFFE);
    checkOutput("model DIV ovf",         refOp(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

    // Directed cases with literal expectations
    applyStimulus(3'd0, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 1'b0, -1, -1);
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 1'b0, -1, -1);
    applyStimulus(3'd3, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 1'b0, -1, -1);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, 1'b0, -1, -1);
    applyStimulus(3'd4, 32'hFFFFFFEC, 32'd3,        5'd6,  32'hFFFFFFFA, 1'b0, -1, -1);
    applyStimulus(3'd6, 32'hFFFFFFEC, 32'd3,        5'd7,  32'hFFFFFFFE, 1'b0, -1, -1);
    applyStimulus(3'd5, 32'hFFFFFFFF, 32'd2,        5'd8,  32'h7FFFFFFF, 1'b0, -1, -1);
    applyStimulus(3'd5, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1'b0, -1, -1);
    applyStimulus(3'd6, 32'd5,        32'd0,        5'd11, 32'd5,        1'b0, -1, -1);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1'b0, -1, -1);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0,        1'b0, -1, -1);

    // Aborts: flush mid-divide, flush in the start cycle, reset mid-multiply
    applyStimulus(3'd4, 32'd1000, 32'd7, 5'd14, refOp(3'd4, 32'd1000, 32'd7), 1'b0, 10, -1);
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 1'b0, 0, -1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd16, 32'd12, 1'b0, -1, 5);

    // start_i held through DONE, then a new op the very next cycle
    applyStimulus(3'd0, 32'd123, 32'd456, 5'd17, 32'd56088, 1'b1, -1, -1);
    applyStimulus(3'd7, 32'd100, 32'd7, 5'd18, 32'd2, 1'b1, -1, -1);
    applyStimulus(3'd5, 32'd9, 32'd0, 5'd19, 32'hFFFFFFFF, 1'b1, -1, -1);
    applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, 5'd20, 32'hFFFFFFFF, 1'b0, -1, -1);

    // Randomized ops against the reference model, with random idle gaps
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = pickVal();
      b  = pickVal();
      applyStimulus(f3, a, b, 5'($urandom), refOp(f3, a, b), 1'($urandom_range(0, 1)), -1, -1);
      repeat ($urandom_range(0, 2)) begin
        op_a   = $urandom;
        funct3 = 3'($urandom);
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
